// File: rtl/m_element_requester_if.sv
// Request/ready stream plus control/result signals between the
// m-element requester, the vector manager and the layer sequencer.
interface m_element_requester_if #(
  parameter int ELEMENTS = 8,
  parameter int DW       = 16,
  parameter int ACC_W    = 40
);
  localparam int AW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

  logic                    start;
  logic                    weight_wr_en;
  logic [AW-1:0]           weight_wr_addr;
  logic signed [DW-1:0]    weight_wr_data;
  logic                    m_element_requested;
  logic                    m_element_ready;
  logic signed [DW-1:0]    m_element;
  logic                    last_element;
  logic signed [ACC_W-1:0] result;
  logic                    result_valid;
  logic                    busy;
  logic                    timeout_error;
  logic                    protocol_error;

  // requester side
  modport master (
    input  start, weight_wr_en, weight_wr_addr, weight_wr_data,
           m_element_ready, m_element, last_element,
    output m_element_requested, result, result_valid, busy,
           timeout_error, protocol_error
  );

  // responder / sequencer side
  modport slave (
    output start, weight_wr_en, weight_wr_addr, weight_wr_data,
           m_element_ready, m_element, last_element,
    input  m_element_requested, result, result_valid, busy,
           timeout_error, protocol_error
  );
endinterface

// File: rtl/m_element_requester.sv
// Requests one filter vector, MACs each returned element against a local
// signed weight bank and presents the dot product with a one-cycle strobe.
module m_element_requester #(
  parameter int ELEMENTS = 8,
  parameter int DW       = 16,
  parameter int ACC_W    = 40,
  parameter int TIMEOUT  = 64
) (
  input  logic                   clock,
  input  logic                   clear_n,
  m_element_requester_if.master  bus
);
  localparam int AW      = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_COLLECT, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW-1:0]           r_count;
  logic [TW-1:0]           r_timer;
  logic signed [ACC_W-1:0] r_acc, r_result;
  logic                    r_last_seen, r_terr, r_perr;
  logic signed [DW-1:0]    r_w [ELEMENTS];

  logic                    w_start, w_strobe, w_final, w_timeout, w_stray, w_no_last;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext, w_acc_nxt;

  assign w_start   = (r_state == S_IDLE) && bus.start;
  assign w_strobe  = (r_state == S_COLLECT) && bus.m_element_ready;
  assign w_final   = w_strobe && (r_count == AW'(ELEMENTS - 1));
  // Timer has run a full TIMEOUT window in COLLECT with no strobe arriving.
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_COLLECT) &&
                     !bus.m_element_ready && (r_timer == TW'(TO_LAST));
  assign w_stray   = bus.m_element_ready && (r_state != S_COLLECT);
  // last_element on the final strobe cycle itself still counts as seen.
  assign w_no_last = w_final && !(r_last_seen || bus.last_element);

  // Full-precision signed product, sign-extended into the wrapping accumulator.
  assign w_prod     = bus.m_element * r_w[r_count];
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_acc_nxt  = r_acc + w_prod_ext;

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt             = r_state;
    bus.m_element_requested = 1'b0;
    bus.result_valid        = 1'b0;
    bus.busy                = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = S_REQUEST;
      end
      S_REQUEST: begin
        bus.m_element_requested = 1'b1;
        w_state_nxt             = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_final)        w_state_nxt = S_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        bus.result_valid = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MAC datapath: accumulator, element index, stall timer, last-seen flag.
  // result is loaded on the final strobe so it is already stable in DONE.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_last_seen <= 1'b0;
      r_result    <= '0;
    end else if (w_start) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_last_seen <= 1'b0;
    end else if (r_state == S_COLLECT) begin
      if (bus.last_element) r_last_seen <= 1'b1;
      if (w_strobe) begin
        r_acc   <= w_acc_nxt;
        r_count <= r_count + 1'b1;
        r_timer <= '0;
        if (w_final) r_result <= w_acc_nxt;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Sticky error flags; an accepted start clears them and beats a same-cycle stray.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_terr <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_start) begin
      r_terr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_timeout)           r_terr <= 1'b1;
      if (w_stray || w_no_last) r_perr <= 1'b1;
    end
  end

  // Weight bank, writable only while idle so an in-flight vector sees stable weights.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < ELEMENTS; i++) r_w[i] <= '0;
    end else if ((r_state == S_IDLE) && bus.weight_wr_en) begin
      r_w[bus.weight_wr_addr] <= bus.weight_wr_data;
    end
  end

  assign bus.result         = r_result;
  assign bus.timeout_error  = r_terr;
  assign bus.protocol_error = r_perr;
endmodule

// File: tb/tb_m_element_requester.sv
// Scoreboarded bench for m_element_requester: the driver pushes the
// hand-computed dot product per vector, a negedge monitor pops on result_valid.
module tb_m_element_requester;
  localparam int ELEMENTS = 8;
  localparam int DW       = 16;
  localparam int ACC_W    = 40;
  localparam int TIMEOUT  = 64;

  typedef struct {
    logic signed [ACC_W-1:0] res;
    logic                    perr;
  } exp_t;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  m_element_requester_if #(.ELEMENTS(ELEMENTS), .DW(DW), .ACC_W(ACC_W)) bus ();

  m_element_requester #(.ELEMENTS(ELEMENTS), .DW(DW), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];
  logic signed [DW-1:0] elem [ELEMENTS];
  logic signed [DW-1:0] wts  [ELEMENTS];
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", {63'd0, bus.result_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("protocol_error_at_result", {63'd0, bus.protocol_error}, {63'd0, e.perr});
        chk("timeout_error_at_result", {63'd0, bus.timeout_error}, 64'd0);
      end
    end
    if (prev_rv) chk("result_valid_one_cycle", {63'd0, bus.result_valid}, 64'd0);
    prev_rv = bus.result_valid;
  end

  task automatic write_weights();
    for (int i = 0; i < ELEMENTS; i++) begin
      @(posedge clock); #1;
      bus.weight_wr_en   = 1'b1;
      bus.weight_wr_addr = 3'(i);
      bus.weight_wr_data = wts[i];
    end
    @(posedge clock); #1;
    bus.weight_wr_en = 1'b0;
  endtask

  // One full vector from the module-level elem[] table.
  task automatic run_vec(input int last_idx, input logic signed [ACC_W-1:0] exp_res,
                         input logic exp_perr, input int gap, input bit disturb,
                         input bit stray_start);
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.m_element_ready = stray_start;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.m_element_ready = 1'b0;
    sb.push_back('{exp_res, exp_perr});
    @(negedge clock);
    chk("request_pulse", {63'd0, bus.m_element_requested}, 64'd1);
    chk("busy_in_request", {63'd0, bus.busy}, 64'd1);
    if (stray_start) chk("start_beats_stray", {63'd0, bus.protocol_error}, 64'd0);
    for (int i = 0; i < ELEMENTS; i++) begin
      @(posedge clock); #1;
      bus.m_element_ready = 1'b1;
      bus.m_element       = elem[i];
      bus.last_element    = (i == last_idx);
      bus.start           = 1'b0;
      bus.weight_wr_en    = 1'b0;
      if (disturb && i == 3) begin
        bus.start          = 1'b1;
        bus.weight_wr_en   = 1'b1;
        bus.weight_wr_addr = 3'd7;
        bus.weight_wr_data = 16'sd100;
      end
      for (int g = 0; g < gap && i < ELEMENTS - 1; g++) begin
        @(posedge clock); #1;
        bus.m_element_ready = 1'b0;
        bus.last_element    = 1'b0;
        bus.start           = 1'b0;
        bus.weight_wr_en    = 1'b0;
      end
    end
    @(posedge clock); #1;
    bus.m_element_ready = 1'b0;
    bus.last_element    = 1'b0;
    bus.start           = 1'b0;
    bus.weight_wr_en    = 1'b0;
    @(negedge clock);
    chk("result_valid_latency", {63'd0, bus.result_valid}, 64'd1);
    @(negedge clock);
    chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.weight_wr_en = 0; bus.weight_wr_addr = '0; bus.weight_wr_data = '0;
    bus.m_element_ready = 0; bus.m_element = '0; bus.last_element = 0;
    #3;
    chk("rst_requested", {63'd0, bus.m_element_requested}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_result_valid", {63'd0, bus.result_valid}, 64'd0);
    chk("rst_terr", {63'd0, bus.timeout_error}, 64'd0);
    chk("rst_perr", {63'd0, bus.protocol_error}, 64'd0);
    @(negedge clock); clear_n = 1'b1;

    // 1: w=1..8, elements 1, last on 6th strobe -> 36
    for (int i = 0; i < ELEMENTS; i++) begin wts[i] = 16'(i + 1); elem[i] = 16'sd1; end
    write_weights();
    run_vec(5, 40'sd36, 1'b0, 0, 1'b0, 1'b0);

    // 2: w=0x7FFF, elements -1 -> 8 * -32767
    for (int i = 0; i < ELEMENTS; i++) begin wts[i] = 16'h7FFF; elem[i] = 16'hFFFF; end
    write_weights();
    run_vec(7, -40'sd262136, 1'b0, 0, 1'b0, 1'b0);

    // 3: no strobes -> timeout after TIMEOUT idle cycles in COLLECT
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (30) @(negedge clock);
    chk("to_still_busy", {63'd0, bus.busy}, 64'd1);
    chk("to_not_early", {63'd0, bus.timeout_error}, 64'd0);
    repeat (50) @(negedge clock);
    chk("to_error", {63'd0, bus.timeout_error}, 64'd1);
    chk("to_busy_low", {63'd0, bus.busy}, 64'd0);
    chk("to_result_held", bus.result, -64'sd262136);

    // 4: reset after 3rd strobe, bank cleared, then a clean run
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1; bus.m_element_ready = 1'b1; bus.m_element = 16'sd1;
    end
    @(posedge clock); #1 bus.m_element_ready = 1'b0;
    #2 clear_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_terr", {63'd0, bus.timeout_error}, 64'd0);
    chk("mid_rst_requested", {63'd0, bus.m_element_requested}, 64'd0);
    @(negedge clock); clear_n = 1'b1;
    for (int i = 0; i < ELEMENTS; i++) elem[i] = 16'sd1;
    run_vec(7, 40'sd0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < ELEMENTS; i++) begin wts[i] = 16'(i + 1); elem[i] = 16'(8 - i); end
    write_weights();
    run_vec(7, 40'sd120, 1'b0, 0, 1'b0, 1'b0);

    // 5: start and weight write (addr 7 <- 100) mid-COLLECT ignored -> 2*36
    for (int i = 0; i < ELEMENTS; i++) elem[i] = 16'sd2;
    run_vec(7, 40'sd72, 1'b0, 0, 1'b1, 1'b0);

    // 6: alternating +/-1, no last_element, gapped strobes -> -4 with protocol_error
    for (int i = 0; i < ELEMENTS; i++) elem[i] = (i % 2 == 0) ? 16'sd1 : -16'sd1;
    run_vec(-1, -40'sd4, 1'b1, 1, 1'b0, 1'b0);
    // start + stray ready same cycle: start wins, clears previous error
    for (int i = 0; i < ELEMENTS; i++) elem[i] = 16'sd1;
    run_vec(0, 40'sd36, 1'b0, 0, 1'b0, 1'b1);
    // stray ready in IDLE
    @(posedge clock); #1 bus.m_element_ready = 1'b1;
    @(posedge clock); #1 bus.m_element_ready = 1'b0;
    @(negedge clock);
    chk("stray_idle_perr", {63'd0, bus.protocol_error}, 64'd1);
    chk("stray_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("stray_result_held", bus.result, 64'd36);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
